// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// in_ready and out_valid come straight from registers, so no combinational path crosses the stage.
module pipe_skid_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   level
);

  localparam int unsigned LW = 2;

  // State value doubles as the held-entry count.
  typedef enum logic [LW-1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_main;
  logic [W-1:0]   r_skid;
  logic           r_out_valid;
  logic           r_in_ready;

  logic w_in_acc;
  logic w_out_acc;

  assign w_in_acc  = in_valid & r_in_ready;
  assign w_out_acc = r_out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else if (flush) begin
      // Flush wins over any handshake this cycle.
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_acc) begin
            r_state     <= ST_ONE;
            r_main      <= in_data;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_acc && w_out_acc) begin
            r_main <= in_data;
          end else if (w_in_acc) begin
            r_state    <= ST_FULL;
            r_skid     <= in_data;
            r_in_ready <= 1'b0;
          end else if (w_out_acc) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (w_out_acc) begin
            r_state    <= ST_ONE;
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign level     = r_state;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// compared against a two-deep FIFO queue model.
module tb_pipe_skid_reg;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   level;

  int n_chk  = 0;
  int n_pass = 0;

  logic [W-1:0] q[$];

  pipe_skid_reg #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Compare outputs with the queue, then advance the queue by the rules for this cycle.
  task automatic step(input logic f, input logic iv, input logic [W-1:0] d, input logic ordy);
    logic can_in;
    logic do_pop;
    flush     = f;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    chk("level", W'(level), W'(q.size()));
    chk("out_valid", W'(out_valid), W'(q.size() > 0));
    chk("in_ready", W'(in_ready), W'(q.size() < 2));
    if (q.size() > 0) chk("out_data", out_data, q[0]);
    if (f) begin
      q.delete();
    end else begin
      can_in = (q.size() < 2);
      do_pop = (q.size() > 0) && ordy;
      if (do_pop) void'(q.pop_front());
      if (iv && can_in) q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_level", W'(level), '0);
    chk("rst_out_data", out_data, '0);
    reset = 1'b0;

    // Streaming: one transfer per cycle, one-cycle latency.
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, W'(i), 1'b1);
      chk("stream_data", out_data, W'(i));
      chk("stream_level", W'(level), W'(1));
      chk("stream_in_ready", W'(in_ready), W'(1));
    end
    step(1'b0, 1'b0, '0, 1'b1);

    // Stall and skid.
    step(1'b0, 1'b1, W'(10), 1'b0);
    step(1'b0, 1'b1, W'(20), 1'b0);
    step(1'b0, 1'b1, W'(30), 1'b0);
    chk("skid_level", W'(level), W'(2));
    chk("skid_in_ready", W'(in_ready), '0);
    chk("skid_head", out_data, W'(10));
    step(1'b0, 1'b1, W'(30), 1'b1);
    chk("release_in_ready", W'(in_ready), W'(1));
    chk("release_data", out_data, W'(20));
    step(1'b0, 1'b1, W'(30), 1'b1);
    chk("release_last", out_data, W'(30));
    step(1'b0, 1'b0, '0, 1'b1);
    chk("drained_level", W'(level), '0);

    // Flush while full.
    step(1'b0, 1'b1, W'(5), 1'b0);
    step(1'b0, 1'b1, W'(6), 1'b0);
    step(1'b1, 1'b1, W'(7), 1'b0);
    chk("flush_level", W'(level), '0);
    chk("flush_out_valid", W'(out_valid), '0);
    chk("flush_out_data", out_data, '0);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    // Simultaneous push and pop in ONE.
    step(1'b0, 1'b1, W'(32'hAA), 1'b0);
    step(1'b0, 1'b1, W'(32'hBB), 1'b1);
    chk("pushpop_data", out_data, W'(32'hBB));
    chk("pushpop_level", W'(level), W'(1));
    step(1'b0, 1'b0, '0, 1'b1);

    // Asynchronous reset between edges while full.
    step(1'b0, 1'b1, W'(1), 1'b0);
    step(1'b0, 1'b1, W'(2), 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset_out_valid", W'(out_valid), '0);
    chk("areset_level", W'(level), '0);
    chk("areset_in_ready", W'(in_ready), W'(1));
    q.delete();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic against the queue model.
    for (int c = 0; c < 10000; c++) begin
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) < 7),
           W'($urandom), ($urandom_range(0, 9) < 6));
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a one-entry skid buffer. It generalises the plain enable/clear stage flop: back-pressure replaces the enable, and a synchronous flush replaces the clear. It lets a pipeline stage stall without a combinational ready path from downstream to upstream, while still sustaining one transfer per cycle. It sits between any two pipeline stages (e.g. IF/ID, ID/EX) whose payload is packed into one bus.

## Interface
- W, 32, payload width in bits (W >= 1)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear; discards all held entries
- in_valid  input  1  upstream presents in_data
- in_ready  output  1  stage can accept; depends only on registered state
- in_data  input  W  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts out_data this cycle
- out_data  output  W  payload of the oldest held entry
- level  output  2  number of held entries (0, 1, 2)

## Operation
- Storage: main register (drives out_data) plus skid register; each is W bits.
- State machine: EMPTY (level 0), ONE (main valid), FULL (main and skid valid).
- out_valid = (state != EMPTY); in_ready = (state != FULL); level encodes the state directly.
- Input accept = in_valid & in_ready. Output accept = out_valid & out_ready.
- EMPTY: on input accept -> ONE, main <= in_data. out_ready is ignored.
- ONE:
  - input and output accept -> stay ONE, main <= in_data.
  - input accept only -> FULL, skid <= in_data.
  - output accept only -> EMPTY.
  - neither -> hold.
- FULL: in_ready = 0, so input is ignored. On output accept -> ONE, main <= skid. Otherwise hold.
- Order is strictly FIFO. No entry is duplicated or dropped except by flush or reset.
- flush = 1 takes priority over every handshake in that cycle:
  - next state is EMPTY; main and skid are cleared to 0.
  - any input accepted that cycle is discarded.
  - out_ready that cycle is irrelevant; the current out_data counts as dropped.
- reset (async) forces state EMPTY and main/skid to 0 immediately, regardless of clk.
- out_data when out_valid = 0:
  - 0 after reset or flush.
  - otherwise holds the last popped value.
  - benches must not check it.
- in_valid with in_ready = 0 has no effect. Upstream must hold in_data/in_valid until accepted; the stage does not check this.

## Timing
- Reset values: out_valid 0, in_ready 1, level 0, out_data 0.
- Latency: data accepted at edge N appears on out_data with out_valid = 1 after edge N (visible in cycle N+1).
- Throughput: one transfer per cycle when out_ready is held high; level stays at 1.
- Back-pressure: when out_ready drops, one further entry is absorbed into skid. in_ready falls after that edge, never combinationally.
- Release from FULL: in_ready returns to 1 the cycle after the output accept.
- No combinational path from out_ready or in_valid to in_ready or out_valid.
- Deassertion of reset is assumed synchronised externally. The first edge after deassertion may accept data.

## Test plan
- Streaming, W=8:
  - stimulus: in_valid = 1, in_data = 1, 2, 3, 4 on consecutive cycles, out_ready = 1.
  - response: out_data = 1, 2, 3, 4 on consecutive cycles, each one cycle after its input; level stays 1; in_ready stays 1.
- Stall and skid:
  - stimulus: stream 10, 20, 30 with out_ready = 0 from the cycle 10 is presented.
  - response: level reaches 2; in_ready = 0; 30 is held off upstream. Release out_ready: out 10, 20, 30 in order; in_ready back to 1 one cycle after the first pop.
- Flush while FULL:
  - stimulus: with entries 5 and 6 held and in_valid = 1 (data 7), assert flush for one cycle.
  - response: next cycle level 0, out_valid 0, out_data 0; 5, 6 and 7 never appear.
- Async reset mid-operation:
  - stimulus: assert reset between clock edges with level 2.
  - response: out_valid 0, level 0, in_ready 1 before the next edge.
- Simultaneous push/pop in ONE:
  - stimulus: main = 0xAA, in_data = 0xBB, in_valid = out_ready = 1.
  - response: 0xAA popped; next cycle out_data 0xBB, level 1.
- Random: random in_valid/out_ready/flush over 10k cycles, W=32, against a scoreboard queue of depth 2.
  - required: order preserved; no loss outside flush; level matches the model every cycle.
